mem_ls_stage: RTL and testbench
===============================

# mem_ls_stage

Parametrised data-memory pipeline stage that replaces the word-only MEM stage. It sits between the AGEX latch and WB. It adds:
- byte/halfword/word loads and stores, with sign or zero extension;
- misalignment detection;
- a configurable multi-cycle read latency;
- valid/ready handshakes on both sides, so the stage can stall AGEX.

Only one instruction is in flight at a time. The stage exports its pending destination register to DE for hazard stalls.

## Interface
- DBITS, 32: data and address width; must be 32.
- DEPTH, 1024: memory depth in words; power of two, at least 16.
- READ_LAT, 1: cycles from load acceptance to result valid; 1..4.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all stage state.
- in_valid  in  1  AGEX presents an instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_op  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; other codes are illegal.
- in_rd_mem  in  1  instruction is a load.
- in_wr_mem  in  1  instruction is a store.
- in_addr  in  DBITS  byte address, computed in AGEX.
- in_wdata  in  DBITS  store data, right-aligned.
- in_aluout  in  DBITS  result for non-memory instructions.
- in_wregno  in  5  destination register.
- in_wr_reg  in  1  instruction writes a register.
- out_valid  out  1  result is valid for WB.
- out_ready  in  1  WB accepts the result.
- out_result  out  DBITS  extended load data, or the passed-through in_aluout.
- out_wregno  out  5  destination register.
- out_wr_reg  out  1  register write enable; forced to 0 on misalignment.
- out_misalign  out  1  access was misaligned, or in_op was illegal for a memory instruction.
- busy_wr_reg  out  1  a register-writing instruction is held in the stage.
- busy_wregno  out  5  destination register of that held instruction.

## Operation
- Memory: DEPTH words of DBITS bits; word index = in_addr[log2(DEPTH)+1:2], so addresses wrap modulo DEPTH*4 bytes. Contents are not reset.
- Alignment:
  - H and HU require addr[0]=0.
  - W requires addr[1:0]=00.
  - Misaligned or illegal-op store: suppressed, out_misalign=1.
  - Misaligned or illegal-op load: out_result=0, out_wr_reg=0, out_misalign=1.
- Store: byte enables are derived from in_op and addr[1:0]. in_wdata[7:0] or [15:0] is replicated into the selected lanes. The write happens on the acceptance edge; unselected bytes are unchanged.
- Load: the addressed word is captured at acceptance, then the byte or half selected by addr[1:0] is extracted.
  - B and H sign-extend; BU and HU zero-extend.
  - When in_rd_mem and in_wr_mem are both set, the store wins and the load is ignored (treated as a store).
- FSM:
  - IDLE: in_ready=1. On in_valid, a load moves to WAIT with cnt=READ_LAT-1 (or straight to HOLD when READ_LAT=1). Any other instruction moves to HOLD.
  - WAIT: cnt decrements each cycle; at cnt=0 the next state is HOLD.
  - HOLD: out_valid=1. If out_ready, go to IDLE, or accept a new instruction in the same cycle (in_ready=out_ready in HOLD).
- busy_wr_reg=1 in WAIT and HOLD when the held instruction has out_wr_reg=1.

## Timing
- Reset values: state IDLE, out_valid=0, out_result=0, out_wregno=0, out_wr_reg=0, out_misalign=0, busy_wr_reg=0, cnt=0.
- Non-load instruction: out_valid=1 one cycle after acceptance.
- Load: out_valid=1 exactly READ_LAT cycles after acceptance.
- Back-to-back: with out_ready held at 1, non-loads sustain 1/cycle; loads sustain 1 per READ_LAT cycles.
- Stall: in HOLD with out_ready=0, all out_* signals are held stable and in_ready=0.
- Reset asserted mid-WAIT or mid-HOLD:
  - the held instruction is dropped and out_valid falls immediately;
  - a store already written stays written.
- in_ready is combinational from state and out_ready. There is no combinational path from in_valid to out_*.

## Test plan
- SW 0xDEADBEEF to 0x100, then LW, LB, LBU and LH from 0x100..0x103 -> results 0xDEADBEEF, 0xFFFFFFEF (byte 0), 0x000000AD (byte 2), 0xFFFFDEAD (half at 0x102).
- SB 0x12 to 0x101 over the word 0xDEADBEEF, then LW 0x100 -> 0xDEAD12EF.
- SH to 0x101 -> out_misalign=1, memory unchanged. LW at 0x102 -> out_result=0, out_wr_reg=0, out_misalign=1.
- READ_LAT=3: LW accepted at cycle N -> out_valid at N+3, in_ready=0 for cycles N+1..N+3, busy_wregno equals the load's rd.
- Hold out_ready=0 for 5 cycles in HOLD -> out_* stable and in_ready=0; on release, a new ALU op is accepted in the same cycle.
- Assert reset during WAIT -> out_valid=0 and state IDLE immediately. Address 0x100+DEPTH*4 aliases to 0x100.

Source files
------------

// File: rtl/mem_ls_stage.sv
// Data-memory pipeline stage: byte/half/word loads and stores with extension,
// misalignment detection, configurable read latency and valid/ready handshakes.
module mem_ls_stage #(
    parameter int DBITS    = 32,
    parameter int DEPTH    = 1024,
    parameter int READ_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic             in_rd_mem,
    input  logic             in_wr_mem,
    input  logic [DBITS-1:0] in_addr,
    input  logic [DBITS-1:0] in_wdata,
    input  logic [DBITS-1:0] in_aluout,
    input  logic [4:0]       in_wregno,
    input  logic             in_wr_reg,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DBITS-1:0] out_result,
    output logic [4:0]       out_wregno,
    output logic             out_wr_reg,
    output logic             out_misalign,
    output logic             busy_wr_reg,
    output logic [4:0]       busy_wregno
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t           state_r;
    logic [CW-1:0]    cnt_r;
    logic [DBITS-1:0] mem_r [DEPTH];

    logic             accept_s;
    logic             is_mem_s;
    logic             is_load_s;
    logic             access_ok_s;
    logic             bad_s;
    logic [AW-1:0]    word_idx_s;
    logic [DBITS-1:0] rd_word_s;
    logic [3:0]       byte_en_s;
    logic [DBITS-1:0] lanes_s;
    logic             do_write_s;
    logic [DBITS-1:0] result_s;
    logic             wr_reg_s;
    logic             unused_s;

    function automatic logic op_legal(input logic [2:0] op);
        case (op)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: op_legal = 1'b1;
            default:                                op_legal = 1'b0;
        endcase
    endfunction

    function automatic logic op_aligned(input logic [2:0] op, input logic [1:0] a);
        case (op[1:0])
            2'b00:   op_aligned = 1'b1;
            2'b01:   op_aligned = (a[0] == 1'b0);
            2'b10:   op_aligned = (a == 2'b00);
            default: op_aligned = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_enable(input logic [2:0] op, input logic [1:0] a);
        case (op[1:0])
            2'b00:   byte_enable = 4'b0001 << a;
            2'b01:   byte_enable = a[1] ? 4'b1100 : 4'b0011;
            2'b10:   byte_enable = 4'b1111;
            default: byte_enable = 4'b0000;
        endcase
    endfunction

    // Narrow store data is replicated so every candidate lane carries it.
    function automatic logic [31:0] store_lanes(input logic [2:0] op, input logic [31:0] wd);
        case (op[1:0])
            2'b00:   store_lanes = {4{wd[7:0]}};
            2'b01:   store_lanes = {2{wd[15:0]}};
            default: store_lanes = wd;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] op, input logic [1:0] a,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{a, 3'b000} +: 8];
        h = a[1] ? word[31:16] : word[15:0];
        case (op)
            3'b000:  load_extract = {{24{b[7]}}, b};
            3'b100:  load_extract = {24'd0, b};
            3'b001:  load_extract = {{16{h[15]}}, h};
            3'b101:  load_extract = {16'd0, h};
            3'b010:  load_extract = word;
            default: load_extract = 32'd0;
        endcase
    endfunction

    assign in_ready    = (state_r == S_IDLE) || ((state_r == S_HOLD) && out_ready);
    assign accept_s    = in_valid && in_ready;
    assign is_mem_s    = in_rd_mem || in_wr_mem;
    assign is_load_s   = in_rd_mem && !in_wr_mem;
    assign access_ok_s = op_legal(in_op) && op_aligned(in_op, in_addr[1:0]);
    assign bad_s       = is_mem_s && !access_ok_s;
    assign word_idx_s  = in_addr[AW+1:2];
    assign rd_word_s   = mem_r[word_idx_s];
    assign byte_en_s   = byte_enable(in_op, in_addr[1:0]);
    assign lanes_s     = store_lanes(in_op, in_wdata);
    assign do_write_s  = accept_s && in_wr_mem && access_ok_s;
    assign unused_s    = ^in_addr[DBITS-1:AW+2];

    // Result and write-enable that the instruction will carry once accepted.
    always_comb begin
        result_s = in_aluout;
        wr_reg_s = in_wr_reg && !bad_s;
        if (is_load_s) begin
            if (access_ok_s) begin
                result_s = load_extract(in_op, in_addr[1:0], rd_word_s);
            end else begin
                result_s = '0;
            end
        end else begin
            result_s = in_aluout;
        end
    end

    // Data memory: byte-lane writes on the acceptance edge, contents not reset.
    always_ff @(posedge clk) begin
        if (do_write_s) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en_s[i]) begin
                    mem_r[word_idx_s][i*8 +: 8] <= lanes_s[i*8 +: 8];
                end
            end
        end
    end

    // Control FSM with registered result, handshake and hazard outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= S_IDLE;
            cnt_r        <= '0;
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_wregno   <= 5'd0;
            out_wr_reg   <= 1'b0;
            out_misalign <= 1'b0;
            busy_wr_reg  <= 1'b0;
            busy_wregno  <= 5'd0;
        end else begin
            case (state_r)
                S_IDLE, S_HOLD: begin
                    if (accept_s) begin
                        out_result   <= result_s;
                        out_wregno   <= in_wregno;
                        out_wr_reg   <= wr_reg_s;
                        out_misalign <= bad_s;
                        busy_wr_reg  <= wr_reg_s;
                        busy_wregno  <= in_wregno;
                        if (is_load_s && (READ_LAT > 1)) begin
                            state_r   <= S_WAIT;
                            cnt_r     <= CW'(READ_LAT - 1);
                            out_valid <= 1'b0;
                        end else begin
                            state_r   <= S_HOLD;
                            cnt_r     <= '0;
                            out_valid <= 1'b1;
                        end
                    end else if ((state_r == S_HOLD) && out_ready) begin
                        state_r     <= S_IDLE;
                        out_valid   <= 1'b0;
                        busy_wr_reg <= 1'b0;
                    end
                end
                S_WAIT: begin
                    // Leave on the cycle the counter reaches zero so the result
                    // appears exactly READ_LAT cycles after acceptance.
                    cnt_r <= cnt_r - 3'd1;
                    if (cnt_r <= 3'd1) begin
                        state_r   <= S_HOLD;
                        out_valid <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= S_IDLE;
                    cnt_r     <= '0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ls_stage.sv
// Scoreboard bench for mem_ls_stage: a byte-array reference model predicts each
// response at acceptance; a monitor compares whenever the stage presents a result.
module tb_mem_ls_stage;

    localparam int DEPTH = 256;
    localparam int RL    = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [2:0]  in_op;
    logic        in_rd_mem, in_wr_mem;
    logic [31:0] in_addr, in_wdata, in_aluout;
    logic [4:0]  in_wregno;
    logic        in_wr_reg;
    logic        out_valid, out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_wregno;
    logic        out_wr_reg, out_misalign;
    logic        busy_wr_reg;
    logic [4:0]  busy_wregno;

    mem_ls_stage #(.DBITS(32), .DEPTH(DEPTH), .READ_LAT(RL)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rd_mem(in_rd_mem), .in_wr_mem(in_wr_mem), .in_addr(in_addr),
        .in_wdata(in_wdata), .in_aluout(in_aluout), .in_wregno(in_wregno),
        .in_wr_reg(in_wr_reg), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_wregno(out_wregno), .out_wr_reg(out_wr_reg),
        .out_misalign(out_misalign), .busy_wr_reg(busy_wr_reg), .busy_wregno(busy_wregno)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  wregno;
        logic        wr_reg;
        logic        mis;
        int          acc;
        int          lat;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    bit         head_seen = 1'b0;
    int         ready_mode = 0;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    logic [7:0] mref [int];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference behaviour: little-endian byte memory, size/alignment rules.
    task automatic model_step(input logic [2:0] op, input logic rd, input logic wr,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] alu, input logic [4:0] rg,
                              input logic wreg, output exp_t e);
        int size;
        bit legal, ok;
        logic [31:0] v, m;
        legal = op inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        size  = (op[1:0] == 2'b00) ? 1 : ((op[1:0] == 2'b01) ? 2 : 4);
        ok    = legal && ((addr % size) == 0);
        e.wregno = rg;
        e.mis    = (rd || wr) && !ok;
        e.wr_reg = wreg && !e.mis;
        e.result = alu;
        e.lat    = 1;
        e.acc    = 0;
        if (wr) begin
            if (ok)
                for (int b = 0; b < size; b++)
                    mref[int'((addr + b) % (DEPTH * 4))] = wdata[8*b +: 8];
        end else if (rd) begin
            e.lat = RL;
            if (ok) begin
                v = 32'd0;
                for (int b = 0; b < size; b++)
                    v = v | (32'(mref[int'((addr + b) % (DEPTH * 4))]) << (8 * b));
                if (!op[2] && size < 4) begin
                    m = (32'd1 << (8 * size)) - 32'd1;
                    if (v[8*size-1]) v = v | ~m;
                end
                e.result = v;
            end else begin
                e.result = 32'd0;
            end
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] alu, input logic [4:0] rg,
                         input logic wreg, output int waits);
        exp_t e;
        @(negedge clk);
        in_op = op; in_rd_mem = rd; in_wr_mem = wr; in_addr = addr;
        in_wdata = wdata; in_aluout = alu; in_wregno = rg; in_wr_reg = wreg;
        in_valid = 1'b1;
        waits = 0;
        #4;
        while (!in_ready && waits < 200) begin
            @(negedge clk);
            #4;
            waits++;
        end
        if (!in_ready) begin
            check("accept_timeout", in_ready, 1'b1);
            in_valid = 1'b0;
        end else begin
            model_step(op, rd, wr, addr, wdata, alu, rg, wreg, e);
            e.acc = cyc;
            exp_q.push_back(e);
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: drives out_ready, compares every presented result to the queue head.
    always @(negedge clk) begin
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
        #3;
        if (!reset && out_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", out_valid, 1'b0);
            end else begin
                mon_e = exp_q[0];
                if (!head_seen) begin
                    check("latency", 64'(cyc), 64'(mon_e.acc + mon_e.lat));
                    head_seen = 1'b1;
                end
                check("result", out_result, mon_e.result);
                check("ctrl", {out_wregno, out_wr_reg, out_misalign},
                      {mon_e.wregno, mon_e.wr_reg, mon_e.mis});
                check("busy", {busy_wr_reg, busy_wr_reg ? busy_wregno : 5'd0},
                      {mon_e.wr_reg, mon_e.wr_reg ? mon_e.wregno : 5'd0});
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    head_seen = 1'b0;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [2:0] ops [10];
        logic [2:0] op;
        logic [31:0] a;
        int kind;
        ops = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101,
                3'b010, 3'b000, 3'b001, 3'b011, 3'b111};
        reset = 1'b1; in_valid = 1'b0; in_op = 3'd0; in_rd_mem = 1'b0; in_wr_mem = 1'b0;
        in_addr = 32'd0; in_wdata = 32'd0; in_aluout = 32'd0; in_wregno = 5'd0; in_wr_reg = 1'b0;
        #12;
        check("reset_outs", {out_valid, out_result, out_wregno, out_wr_reg, out_misalign},
              {1'b0, 32'd0, 5'd0, 1'b0, 1'b0});
        check("reset_busy", {busy_wr_reg, busy_wregno}, {1'b0, 5'd0});
        check("reset_in_ready", in_ready, 1'b1);
        @(negedge clk) reset = 1'b0;

        // Directed loads/stores around 0x100
        issue(3'b010, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 32'h0, 5'd1, 1'b0, w);
        issue(3'b010, 1'b1, 1'b0, 32'h100, 32'h0, 32'h0, 5'd2, 1'b1, w);
        issue(3'b000, 1'b1, 1'b0, 32'h100, 32'h0, 32'h0, 5'd3, 1'b1, w);
        issue(3'b100, 1'b1, 1'b0, 32'h102, 32'h0, 32'h0, 5'd4, 1'b1, w);
        issue(3'b001, 1'b1, 1'b0, 32'h102, 32'h0, 32'h0, 5'd5, 1'b1, w);
        issue(3'b000, 1'b0, 1'b1, 32'h101, 32'h12, 32'h0, 5'd6, 1'b0, w);
        issue(3'b010, 1'b1, 1'b0, 32'h100, 32'h0, 32'h0, 5'd7, 1'b1, w);
        issue(3'b001, 1'b0, 1'b1, 32'h101, 32'hBEEF, 32'h0, 5'd8, 1'b0, w);
        issue(3'b010, 1'b1, 1'b0, 32'h100, 32'h0, 32'h0, 5'd9, 1'b1, w);
        issue(3'b010, 1'b1, 1'b0, 32'h102, 32'h0, 32'h0, 5'd10, 1'b1, w);
        issue(3'b010, 1'b1, 1'b0, 32'h100 + DEPTH * 4, 32'h0, 32'h0, 5'd11, 1'b1, w);
        issue(3'b011, 1'b1, 1'b0, 32'h100, 32'h0, 32'h0, 5'd12, 1'b1, w);
        issue(3'b011, 1'b0, 1'b0, 32'h33, 32'h0, 32'h12345678, 5'd13, 1'b1, w);
        issue(3'b000, 1'b1, 1'b1, 32'h104, 32'hA5, 32'h0, 5'd14, 1'b1, w);
        issue(3'b100, 1'b1, 1'b0, 32'h104, 32'h0, 32'h0, 5'd15, 1'b1, w);
        drain();

        // Read latency with WB stalled, then hold stability and same-cycle release
        ready_mode = 2;
        issue(3'b010, 1'b1, 1'b0, 32'h100, 32'h0, 32'h0, 5'd21, 1'b1, w);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #4;
            check("lat_in_ready", in_ready, 1'b0);
            check("lat_out_valid", out_valid, (i == 2) ? 1'b1 : 1'b0);
            check("lat_busy_wregno", busy_wregno, 5'd21);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #4;
            check("stall_in_ready", in_ready, 1'b0);
        end
        ready_mode = 0;
        issue(3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0BADF00D, 5'd22, 1'b1, w);
        check("release_accept_waits", 64'(w), 64'd0);
        drain();

        // Reset in the middle of a load wait
        issue(3'b010, 1'b1, 1'b0, 32'h100, 32'h0, 32'h0, 5'd23, 1'b1, w);
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        head_seen = 1'b0;
        #1;
        check("rst_wait_out_valid", out_valid, 1'b0);
        check("rst_wait_idle", {in_ready, busy_wr_reg}, {1'b1, 1'b0});
        @(negedge clk) reset = 1'b0;

        // Reset while a store is held: the write must survive
        ready_mode = 2;
        issue(3'b010, 1'b0, 1'b1, 32'h200, 32'hCAFEF00D, 32'h0, 5'd0, 1'b0, w);
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        head_seen = 1'b0;
        #1;
        check("rst_hold_out_valid", out_valid, 1'b0);
        @(negedge clk) reset = 1'b0;
        ready_mode = 0;
        issue(3'b010, 1'b1, 1'b0, 32'h200, 32'h0, 32'h0, 5'd24, 1'b1, w);
        drain();

        // Randomized traffic over an initialised window, with random WB backpressure
        for (int i = 0; i < 16; i++)
            issue(3'b010, 1'b0, 1'b1, 32'h100 + 4 * i, $urandom, 32'h0, 5'd0, 1'b0, w);
        ready_mode = 1;
        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 9);
            op   = ops[$urandom_range(0, 9)];
            a    = 32'h100 + $urandom_range(0, 63) + DEPTH * 4 * $urandom_range(0, 3);
            if (kind < 4)
                issue(op, 1'b1, 1'b0, a, $urandom, $urandom, 5'($urandom), 1'($urandom), w);
            else if (kind < 7)
                issue(op, 1'b0, 1'b1, a, $urandom, $urandom, 5'($urandom), 1'($urandom), w);
            else if (kind < 9)
                issue(op, 1'b0, 1'b0, a, $urandom, $urandom, 5'($urandom), 1'($urandom), w);
            else
                issue(op, 1'b1, 1'b1, a, $urandom, $urandom, 5'($urandom), 1'($urandom), w);
        end
        drain();
        ready_mode = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
